// File: rtl/ender_timekeeper.sv
// ender_timekeeper: 24-hour BCD time-of-day clock with a 12/24-hour display
// formatter, two debounced auto-repeat set buttons and a minute-resolution alarm.
module ender_timekeeper #(
  parameter int unsigned TICK_DIV = 32768,
  parameter int unsigned DEBOUNCE = 512,
  parameter int unsigned REPEAT   = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_12h,
  input  logic       btn_min_n,
  input  logic       btn_hr_n,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       pm,
  output logic       sec_pulse,
  output logic       alarm_hit
);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} deb_state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE - 1);
  localparam logic [23:0] REP_LAST  = 24'(REPEAT - 1);

  // Returns {carry, next} for a BCD value counting 00..59.
  function automatic logic [8:0] inc_bcd60(input logic [7:0] v);
    if (v[3:0] != 4'd9)      inc_bcd60 = {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) inc_bcd60 = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     inc_bcd60 = 9'h100;
  endfunction

  // Returns {carry, next} for a BCD value counting 00..23.
  function automatic logic [8:0] inc_bcd24(input logic [7:0] v);
    if (v == 8'h23)          inc_bcd24 = 9'h100;
    else if (v[3:0] != 4'd9) inc_bcd24 = {1'b0, v[7:4], v[3:0] + 4'd1};
    else                     inc_bcd24 = {1'b0, v[7:4] + 4'd1, 4'd0};
  endfunction

  // Maps a 24-hour BCD hour to its 12-hour BCD display value (00 -> 12).
  function automatic logic [7:0] to_12h(input logic [7:0] v);
    logic [4:0] h;
    logic [4:0] r;
    h = 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
    if (h == 5'd0)       r = 5'd12;
    else if (h > 5'd12)  r = h - 5'd12;
    else                 r = h;
    if (r >= 5'd10) to_12h = {4'd1, 4'(r - 5'd10)};
    else            to_12h = {4'd0, r[3:0]};
  endfunction

  // Button index 0 advances minutes, index 1 advances hours.
  logic [1:0] btn_n;
  logic [1:0] btn_evt;
  assign btn_n = {btn_hr_n, btn_min_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic       sync1_reg;
    logic       sync2_reg;
    logic       pressed;
    logic       evt;
    deb_state_t state_reg;
    deb_state_t state_next;
    logic [23:0] cnt_reg;
    logic [23:0] cnt_next;

    assign pressed     = ~sync2_reg;
    assign btn_evt[gi] = evt;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_reg <= 1'b1;
        sync2_reg <= 1'b1;
      end else begin
        sync1_reg <= btn_n[gi];
        sync2_reg <= sync1_reg;
      end
    end

    // Debounce FSM state and shared debounce/repeat counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg <= IDLE;
        cnt_reg   <= 24'd0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
      end
    end

    // Next state: the entering sample counts as the first debounce cycle.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      evt        = 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_next = 24'd0;
          if (pressed) begin
            state_next = PRESS_DEB;
            cnt_next   = 24'd1;
          end
        end
        PRESS_DEB: begin
          if (!pressed) begin
            state_next = IDLE;
            cnt_next   = 24'd0;
          end else if (cnt_reg == DEB_LAST) begin
            state_next = HELD;
            cnt_next   = 24'd0;
            evt        = 1'b1;
          end else begin
            cnt_next = cnt_reg + 24'd1;
          end
        end
        HELD: begin
          if (!pressed) begin
            state_next = REL_DEB;
            cnt_next   = 24'd1;
          end else if (cnt_reg == REP_LAST) begin
            cnt_next = 24'd0;
            evt      = 1'b1;
          end else begin
            cnt_next = cnt_reg + 24'd1;
          end
        end
        REL_DEB: begin
          if (pressed) begin
            state_next = HELD;
            cnt_next   = 24'd0;
          end else if (cnt_reg == DEB_LAST) begin
            state_next = IDLE;
            cnt_next   = 24'd0;
          end else begin
            cnt_next = cnt_reg + 24'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 24'd0;
        end
      endcase
    end
  end

  logic        evt_min;
  logic        evt_hr;
  logic [23:0] pre_reg;
  logic [23:0] pre_next;
  logic        tick;
  logic [7:0]  sec_reg, min_reg, hr_reg;
  logic [7:0]  sec_next, min_next, hr_next;
  logic [7:0]  hr_disp_reg;
  logic        pm_reg;
  logic        sec_pulse_reg;
  logic        sec_upd;
  logic        alarm_reg;
  logic        alarm_next;
  logic [8:0]  sec_inc, min_inc, hr_inc;

  assign evt_min = btn_evt[0];
  assign evt_hr  = btn_evt[1];
  assign tick    = (pre_reg == TICK_LAST);
  assign sec_inc = inc_bcd60(sec_reg);
  assign min_inc = inc_bcd60(min_reg);
  assign hr_inc  = inc_bcd24(hr_reg);

  // Time update: a minute event overrides the tick; an hour event overrides any tick carry.
  always_comb begin
    sec_next   = sec_reg;
    min_next   = min_reg;
    hr_next    = hr_reg;
    pre_next   = tick ? 24'd0 : pre_reg + 24'd1;
    sec_upd    = 1'b0;
    if (evt_min) begin
      min_next = min_inc[7:0];
      sec_next = 8'h00;
      pre_next = 24'd0;
      sec_upd  = 1'b1;
    end else if (tick) begin
      sec_next = sec_inc[7:0];
      sec_upd  = 1'b1;
      if (sec_inc[8]) begin
        min_next = min_inc[7:0];
        if (min_inc[8]) hr_next = hr_inc[7:0];
      end
    end
    if (evt_hr) hr_next = hr_inc[7:0];
    // Internal time is always legal BCD, so an out-of-range alarm setting cannot match.
    alarm_next = alarm_en && (sec_upd || evt_hr) && (hr_next == alarm_hr) &&
                 (min_next == alarm_min) && (sec_next == 8'h00);
  end

  // Time, prescaler and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg       <= 24'd0;
      sec_reg       <= 8'h00;
      min_reg       <= 8'h00;
      hr_reg        <= 8'h00;
      hr_disp_reg   <= mode_12h ? 8'h12 : 8'h00;
      pm_reg        <= 1'b0;
      sec_pulse_reg <= 1'b0;
      alarm_reg     <= 1'b0;
    end else begin
      pre_reg       <= pre_next;
      sec_reg       <= sec_next;
      min_reg       <= min_next;
      hr_reg        <= hr_next;
      hr_disp_reg   <= mode_12h ? to_12h(hr_next) : hr_next;
      pm_reg        <= (hr_next >= 8'h12);
      sec_pulse_reg <= sec_upd;
      alarm_reg     <= alarm_next;
    end
  end

  assign sec_bcd   = sec_reg;
  assign min_bcd   = min_reg;
  assign hr_bcd    = hr_disp_reg;
  assign pm        = pm_reg;
  assign sec_pulse = sec_pulse_reg;
  assign alarm_hit = alarm_reg;

endmodule

// File: tb/tb_ender_timekeeper.sv
// Directed testbench for ender_timekeeper with small divider/debounce/repeat values.
module tb_ender_timekeeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_12h = 1'b0;
  logic       btn_min_n = 1'b1;
  logic       btn_hr_n = 1'b1;
  logic       alarm_en = 1'b0;
  logic [7:0] alarm_hr = 8'h00;
  logic [7:0] alarm_min = 8'h00;
  logic [7:0] sec_bcd, min_bcd, hr_bcd;
  logic       pm, sec_pulse, alarm_hit;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ender_timekeeper #(.TICK_DIV(4), .DEBOUNCE(3), .REPEAT(8)) dut (
    .clk(clk), .rst(rst), .mode_12h(mode_12h),
    .btn_min_n(btn_min_n), .btn_hr_n(btn_hr_n),
    .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hr_bcd(hr_bcd),
    .pm(pm), .sec_pulse(sec_pulse), .alarm_hit(alarm_hit)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_min_n = 1'b1;
    btn_hr_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_sec(input logic [7:0] target);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (sec_bcd !== target && n < 400);
    check8("wait_sec", sec_bcd, target);
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (sec_pulse !== 1'b1 && n < 10);
    check1("pulse_seen", sec_pulse, 1'b1);
  endtask

  // Sets hours then minutes by holding the buttons (24-hour display assumed).
  task automatic set_hm(input logic [7:0] h, input logic [7:0] m);
    int n;
    if (hr_bcd !== h) begin
      btn_hr_n = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (hr_bcd !== h && n < 600);
      btn_hr_n = 1'b1;
      check8("set_hr", hr_bcd, h);
      repeat (8) @(negedge clk);
    end
    if (min_bcd !== m) begin
      btn_min_n = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (min_bcd !== m && n < 600);
      btn_min_n = 1'b1;
      check8("set_min", min_bcd, m);
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic run_alarm(input logic en, input logic [7:0] ahr, input int exp_hits);
    int hits;
    do_reset();
    alarm_en = en;
    alarm_hr = ahr;
    alarm_min = 8'h30;
    set_hm(8'h07, 8'h29);
    wait_sec(8'h58);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alarm_hit === 1'b1) begin
        hits++;
        check8("alarm_at_hr", hr_bcd, 8'h07);
        check8("alarm_at_min", min_bcd, 8'h30);
        check8("alarm_at_sec", sec_bcd, 8'h00);
      end
    end
    check8("alarm_hits", 8'(hits), 8'(exp_hits));
    $display("alarm case en=%b hr=%h: hits=%0d", en, ahr, hits);
    alarm_en = 1'b0;
  endtask

  initial begin
    // Reset state in 12-hour mode, then a live mode switch.
    mode_12h = 1'b1;
    do_reset();
    check8("rst_hr12", hr_bcd, 8'h12);
    check8("rst_sec", sec_bcd, 8'h00);
    check8("rst_min", min_bcd, 8'h00);
    check1("rst_pm", pm, 1'b0);
    check1("rst_pulse", sec_pulse, 1'b0);
    check1("rst_alarm", alarm_hit, 1'b0);
    mode_12h = 1'b0;
    @(negedge clk);
    check8("mode24_hr", hr_bcd, 8'h00);
    $display("reset and mode switch checked");

    // Free-running seconds after reset release.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check1("tick_pulse", sec_pulse, (i % 4) == 0);
      if ((i % 4) == 0) check8("tick_sec", sec_bcd, 8'(i / 4));
    end
    $display("prescaler run checked, sec=%h", sec_bcd);

    // Glitch rejection, debounce latency and auto-repeat on the minute button.
    do_reset();
    btn_min_n = 1'b0;
    repeat (2) @(negedge clk);
    btn_min_n = 1'b1;
    repeat (8) @(negedge clk);
    check8("glitch_min", min_bcd, 8'h00);
    btn_min_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4)  check8("deb_min_before", min_bcd, 8'h00);
      if (i == 5) begin
        check8("deb_min_first", min_bcd, 8'h01);
        check8("deb_sec_first", sec_bcd, 8'h00);
        check1("deb_pulse_first", sec_pulse, 1'b1);
      end
      if (i == 12) check8("rep_min_before", min_bcd, 8'h01);
      if (i == 13) begin
        check8("rep_min_second", min_bcd, 8'h02);
        check8("rep_sec_second", sec_bcd, 8'h00);
      end
      if (i == 20) btn_min_n = 1'b1;
      if (i == 21) begin
        check8("rep_min_third", min_bcd, 8'h03);
        check8("rep_sec_third", sec_bcd, 8'h00);
      end
      if (i == 30) check8("rel_min_final", min_bcd, 8'h03);
    end
    $display("minute button checked, min=%h", min_bcd);

    // Hour event coinciding with the tick at 10:59:59 and at 23:59:59.
    do_reset();
    set_hm(8'h10, 8'h59);
    wait_sec(8'h58);
    repeat (3) @(negedge clk);
    btn_hr_n = 1'b0;
    repeat (4) @(negedge clk);
    check8("coinc1_hr_before", hr_bcd, 8'h10);
    check8("coinc1_sec_before", sec_bcd, 8'h59);
    @(negedge clk);
    check8("coinc1_hr", hr_bcd, 8'h11);
    check8("coinc1_min", min_bcd, 8'h00);
    check8("coinc1_sec", sec_bcd, 8'h00);
    check1("coinc1_pulse", sec_pulse, 1'b1);
    btn_hr_n = 1'b1;
    repeat (10) @(negedge clk);
    check8("coinc1_hr_stable", hr_bcd, 8'h11);
    $display("coincident hour event at 10:59:59 -> %h:%h", hr_bcd, min_bcd);
    set_hm(8'h23, 8'h59);
    wait_sec(8'h58);
    repeat (3) @(negedge clk);
    btn_hr_n = 1'b0;
    repeat (4) @(negedge clk);
    check8("coinc2_hr_before", hr_bcd, 8'h23);
    @(negedge clk);
    check8("coinc2_hr", hr_bcd, 8'h00);
    check8("coinc2_min", min_bcd, 8'h00);
    check8("coinc2_sec", sec_bcd, 8'h00);
    check1("coinc2_pm", pm, 1'b0);
    btn_hr_n = 1'b1;
    repeat (10) @(negedge clk);
    check8("coinc2_hr_stable", hr_bcd, 8'h00);
    $display("coincident hour event at 23:59:59 -> %h:%h", hr_bcd, min_bcd);

    // Midnight rollover with 12-hour display.
    do_reset();
    set_hm(8'h23, 8'h59);
    wait_sec(8'h58);
    mode_12h = 1'b1;
    @(negedge clk);
    check8("roll_hr12_2358", hr_bcd, 8'h11);
    check1("roll_pm_2358", pm, 1'b1);
    check8("roll_min_2358", min_bcd, 8'h59);
    wait_pulse();
    check8("roll_sec_59", sec_bcd, 8'h59);
    check8("roll_hr12_59", hr_bcd, 8'h11);
    check1("roll_pm_59", pm, 1'b1);
    wait_pulse();
    check8("roll_sec_00", sec_bcd, 8'h00);
    check8("roll_min_00", min_bcd, 8'h00);
    check8("roll_hr12_00", hr_bcd, 8'h12);
    check1("roll_pm_00", pm, 1'b0);
    mode_12h = 1'b0;
    @(negedge clk);
    check8("roll_hr24_00", hr_bcd, 8'h00);
    $display("midnight rollover checked");

    // Alarm: enabled, disabled, out-of-range hour.
    run_alarm(1'b1, 8'h07, 1);
    run_alarm(1'b0, 8'h07, 0);
    run_alarm(1'b1, 8'h24, 0);

    // Reset while the hour button is in auto-repeat.
    do_reset();
    btn_hr_n = 1'b0;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (hr_bcd !== 8'h01 && n < 20);
      check8("held_first_evt", hr_bcd, 8'h01);
    end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check8("midrst_hr", hr_bcd, 8'h00);
    check8("midrst_min", min_bcd, 8'h00);
    check8("midrst_sec", sec_bcd, 8'h00);
    check1("midrst_pm", pm, 1'b0);
    check1("midrst_pulse", sec_pulse, 1'b0);
    check1("midrst_alarm", alarm_hit, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check8("midrst_no_evt", hr_bcd, 8'h00);
    end
    @(negedge clk);
    check8("midrst_requal", hr_bcd, 8'h01);
    btn_hr_n = 1'b1;
    $display("reset during repeat checked, hr=%h", hr_bcd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
